// File: rtl/alu_div16_seq.sv
// Sequential restoring divider: one shift/trial-subtract step per clock, MSB first.
// Signed operands are divided as magnitudes and the signs are restored when the result is written.
module alu_div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovfl
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL   = {1'b0, {(WIDTH-1){1'b1}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;
    logic             a_neg;
    logic             b_neg;

    // The dividend register doubles as the quotient: dividend bits shift out the top as quotient bits enter the bottom.
    always_comb begin
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr_q};
        qbit   = ~trial[WIDTH];
        rem_nx = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nx = {dvd_q[WIDTH-2:0], qbit};
        a_neg  = signed_op & dividend[WIDTH-1];
        b_neg  = signed_op & divisor[WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        sat_d   = sat_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dz_d    = 1'b0;
                    ov_d    = 1'b0;
                    count_d = '0;
                    rem_d   = '0;
                    dvd_d   = a_neg ? -dividend : dividend;
                    dsr_d   = b_neg ? -divisor : divisor;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    sat_d   = signed_op && (dividend == MIN_VAL) && (divisor == '1);
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d   = rem_nx;
                dvd_d   = dvd_nx;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = S_DONE;
                    count_d = '0;
                    // MIN / -1 has no representable quotient; saturate instead of wrapping.
                    if (sat_q) begin
                        quo_d = MAX_VAL;
                        rmd_d = '0;
                        ov_d  = 1'b1;
                    end else begin
                        quo_d = qneg_q ? -dvd_nx : dvd_nx;
                        rmd_d = rneg_q ? -rem_nx : rem_nx;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            sat_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            sat_q   <= sat_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;
    assign ovfl      = ov_q;
endmodule

// File: tb/tb_alu_div16_seq.sv
// Bench for alu_div16_seq: directed corner cases plus random operands checked against
// an integer-arithmetic reference; a monitor pops expected results whenever done is high.
module tb_alu_div16_seq;
  localparam int W = 16;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         ovfl;

  // Expected entry: {issue_cycle[31:0], div_zero, ovfl, quotient[15:0], remainder[15:0]}
  logic [65:0] exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int busy_run = 0;

  alu_div16_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .ovfl(ovfl)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  // Reference: plain integer division; returns {div_zero, ovfl, q, r}
  function automatic logic [33:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, qi, ri;
    logic [W-1:0] q, r;
    if (b == 0) return {1'b1, 1'b0, 16'hFFFF, a};
    if (s) begin
      sa = int'(signed'(a));
      sb = int'(signed'(b));
      if (sa == -32768 && sb == -1) return {1'b0, 1'b1, 16'h7FFF, 16'h0000};
      qi = sa / sb;
      ri = sa % sb;
    end else begin
      sa = int'(a);
      sb = int'(b);
      qi = sa / sb;
      ri = sa % sb;
    end
    q = qi[W-1:0];
    r = ri[W-1:0];
    return {1'b0, 1'b0, q, r};
  endfunction

  // ---------------- driver ----------------
  task automatic wait_idle();
    int t = 0;
    while (busy && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) timeout_fail("wait_idle");
  endtask

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    logic [31:0] c;
    wait_idle();
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    c = cyc;
    if (push) exp_q.push_back({c, model(s, a, b)});
    @(negedge clk);
    start     = 1'b0;
    signed_op = 1'($urandom_range(0, 1));
    dividend  = W'($urandom);
    divisor   = W'($urandom);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [65:0] e;
    int lat;
    forever begin
      @(negedge clk);
      if (busy) busy_run++;
      else busy_run = 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done high with no outstanding op (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          lat = e[33] ? 1 : 17;
          check("quotient", 32'(quotient), 32'(e[31:16]));
          check("remainder", 32'(remainder), 32'(e[15:0]));
          check("div_zero", 32'(div_zero), 32'(e[33]));
          check("ovfl", 32'(ovfl), 32'(e[32]));
          check("latency", 32'(cyc) - e[65:34], 32'(lat));
          check("busy_cycles", 32'(busy_run), 32'(lat));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] dir_a [10] = '{16'd100, 16'hFF9C, 16'd100, 16'd5, 16'd5,
                               16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000};
  logic [W-1:0] dir_b [10] = '{16'd7, 16'h0007, 16'hFFF9, 16'd0, 16'd0,
                               16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001};
  logic         dir_s [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int t;
    logic [W-1:0] ra, rb;
    logic rs;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_ovfl", 32'(ovfl), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) issue(dir_s[i], dir_a[i], dir_b[i], 1'b1);

    // start held high through RUN with different operands: only the original result
    // appears, and the held request is taken in the first IDLE cycle after done.
    wait_idle();
    signed_op = 1'b0;
    dividend  = 16'd1000;
    divisor   = 16'd3;
    start     = 1'b1;
    exp_q.push_back({32'(cyc), model(1'b0, 16'd1000, 16'd3)});
    @(negedge clk);
    signed_op = 1'b1;
    dividend  = 16'hFF00;
    divisor   = 16'h0007;
    t = 0;
    while (!done && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) timeout_fail("held_start_done");
    exp_q.push_back({32'(cyc + 1), model(1'b1, 16'hFF00, 16'h0007)});
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;

    // Reset at iteration 8 aborts the op without a done pulse.
    issue(1'b0, 16'd100, 16'd7, 1'b1);
    issue(1'b0, 16'h1234, 16'h0005, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    check("abort_ovfl", 32'(ovfl), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 16'hFFFF, 16'h0010, 1'b1);

    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin rs = 1'b1; ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = W'($urandom_range(1, 15));
        3: rb = 16'hFFFF;
        default: ;
      endcase
      issue(rs, ra, rb, 1'b1);
    end

    t = 0;
    while (exp_q.size() != 0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
